carbiter1z4: RTL and testbench

CARBITER1Z4 -- requirements
Module: carbiter1z4

---
 rtl/carbiter1z4.sv | 129 ++++++++++++
 tb/tb_carbiter1z4.sv | 134 +++++++++++++
 2 files changed

// File: rtl/carbiter1z4.sv
// Four-requester round-robin arbiter with registered one-hot grant and a one-cycle dead time
// between tenures. Define CARBITER1Z4_TIMEOUT_EN to bound each tenure to HOLD_MAX cycles.
module carbiter1z4 #(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic       selA,
    output logic       selB,
    output logic       busy,
    output logic       tout
);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StGrant = 2'b01,
        StGap   = 2'b10
    } state_e;

    if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_hold_max_check
        $error("HOLD_MAX out of range 2..255");
    end

    state_e     state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] last_q, last_d;
    logic [1:0] sel_q, sel_d;
    logic       win_valid;
    logic [1:0] win_idx;

`ifdef CARBITER1Z4_TIMEOUT_EN
    localparam logic [7:0] HoldLast = 8'(HOLD_MAX - 1);
    logic [7:0] cnt_q, cnt_d;
    logic       tout_q, tout_d;
`endif

    // Scan from farthest (last) to nearest (last+1) so the nearest asserted request wins.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = last_q;
        for (int k = 4; k >= 1; k--) begin
            if (req[last_q + k[1:0]]) begin
                win_valid = 1'b1;
                win_idx   = last_q + k[1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        sel_d   = sel_q;
`ifdef CARBITER1Z4_TIMEOUT_EN
        cnt_d   = cnt_q;
        tout_d  = 1'b0;
`endif
        unique case (state_q)
            StIdle, StGap: begin
                gnt_d   = 4'b0000;
                state_d = StIdle;
                if (win_valid) begin
                    state_d = StGrant;
                    gnt_d   = 4'b0001 << win_idx;
                    last_d  = win_idx;
                    sel_d   = win_idx;
`ifdef CARBITER1Z4_TIMEOUT_EN
                    cnt_d   = 8'd0;
`endif
                end
            end
            StGrant: begin
                if (!req[last_q]) begin
                    state_d = StGap;
                    gnt_d   = 4'b0000;
                end
`ifdef CARBITER1Z4_TIMEOUT_EN
                else if (cnt_q == HoldLast) begin
                    // Pointer stays at the revoked index so the others win the next GAP.
                    state_d = StGap;
                    gnt_d   = 4'b0000;
                    tout_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            default: begin
                state_d = StIdle;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            gnt_q   <= 4'b0000;
            last_q  <= 2'd3;
            sel_q   <= 2'd0;
`ifdef CARBITER1Z4_TIMEOUT_EN
            cnt_q   <= 8'd0;
            tout_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
`ifdef CARBITER1Z4_TIMEOUT_EN
            cnt_q   <= cnt_d;
            tout_q  <= tout_d;
`endif
        end
    end

    assign gnt  = gnt_q;
    assign selA = sel_q[0];
    assign selB = sel_q[1];
    assign busy = |gnt_q;
`ifdef CARBITER1Z4_TIMEOUT_EN
    assign tout = tout_q;
`else
    assign tout = 1'b0;
`endif

endmodule

// File: tb/tb_carbiter1z4.sv
// Scoreboard bench for carbiter1z4: directed vectors push expected outputs, a monitor pops
// and compares after each rising edge and also checks grant/select consistency every cycle.
module tb_carbiter1z4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic       selA, selB, busy, tout;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       tout;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    carbiter1z4 #(.HOLD_MAX(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (req),
        .gnt  (gnt),
        .selA (selA),
        .selB (selB),
        .busy (busy),
        .tout (tout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, want);
        end
    endtask

    // Apply inputs before the next edge; expected values describe outputs after that edge.
    task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] g,
                        input logic [1:0] s, input logic t);
        exp_t e;
        @(negedge clk);
        rst_n = r;
        req   = rq;
        e.gnt  = g;
        e.sel  = s;
        e.tout = t;
        exp_q.push_back(e);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("gnt", 32'(gnt), 32'(e.gnt));
            check("sel", 32'({selB, selA}), 32'(e.sel));
            check("tout", 32'(tout), 32'(e.tout));
        end
        check("onehot0", 32'($onehot0(gnt)), 32'd1);
        check("busy", 32'(busy), 32'(|gnt));
        if (busy) check("sel_match", 32'(gnt), 32'(4'b0001 << {selB, selA}));
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] oh;
        // Reset, single requester, release, back to idle.
        step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0);
        step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0);
        step(1'b1, 4'b0001, 4'b0001, 2'd0, 1'b0);
        step(1'b1, 4'b0001, 4'b0001, 2'd0, 1'b0);
        step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0);
        step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0);
        step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0);

        // All four requesting: 0,1,2,3,0 with one dead cycle between tenures.
        step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            oh = 4'b0001 << (i % 4);
            for (int c = 0; c < 3; c++) step(1'b1, 4'b1111, oh, 2'(i % 4), 1'b0);
            step(1'b1, 4'b1111 & ~oh, 4'b0000, 2'(i % 4), 1'b0);
        end
        step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0);

        // No preemption: requester 2 holds while 0 waits.
        step(1'b1, 4'b0100, 4'b0100, 2'd2, 1'b0);
        step(1'b1, 4'b0101, 4'b0100, 2'd2, 1'b0);
        step(1'b1, 4'b0101, 4'b0100, 2'd2, 1'b0);
        step(1'b1, 4'b0001, 4'b0000, 2'd2, 1'b0);
        step(1'b1, 4'b0001, 4'b0001, 2'd0, 1'b0);
        step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0);
        step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0);

        // Reset in the middle of a tenure at index 3.
        step(1'b1, 4'b1000, 4'b1000, 2'd3, 1'b0);
        step(1'b1, 4'b1000, 4'b1000, 2'd3, 1'b0);
        step(1'b0, 4'b1000, 4'b0000, 2'd0, 1'b0);
        step(1'b1, 4'b1000, 4'b1000, 2'd3, 1'b0);
        step(1'b1, 4'b0000, 4'b0000, 2'd3, 1'b0);
        step(1'b1, 4'b0000, 4'b0000, 2'd3, 1'b0);

        // Long hold with two requesters.
        step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0);
`ifdef CARBITER1Z4_TIMEOUT_EN
        for (int c = 0; c < 4; c++) step(1'b1, 4'b0011, 4'b0001, 2'd0, 1'b0);
        step(1'b1, 4'b0011, 4'b0000, 2'd0, 1'b1);
        for (int c = 0; c < 4; c++) step(1'b1, 4'b0011, 4'b0010, 2'd1, 1'b0);
        step(1'b1, 4'b0011, 4'b0000, 2'd1, 1'b1);
        step(1'b1, 4'b0011, 4'b0001, 2'd0, 1'b0);
        step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0);
`else
        for (int c = 0; c < 12; c++) step(1'b1, 4'b0011, 4'b0001, 2'd0, 1'b0);
        step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0);
`endif
        step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0);

        repeat (2) @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
